sync_bus_stable_capture: RTL

//  Downstream consumer of the 2-flop bus synchronizer, in the destination (clk_b) domain.
//  A multi-bit bus through plain 2-flop sync can show skewed/incoherent words for a cycle or more.

---
 rtl/sync_bus_stable_capture.sv | 110 +++++++++++
 1 files changed

// File: rtl/sync_bus_stable_capture.sv
// sync_bus_stable_capture
// Sits in the clk_b domain after a plain 2-flop bus synchronizer. A new bus word
// is committed to data_out only after it has been sampled unchanged on
// STABLE_CYCLES consecutive clk_b edges. Skewed or transient words are rejected
// and counted in a saturating glitch counter.
//
// Interface: there is no valid/ready handshake. data_sync is sampled on every
// clk_b edge while en=1. data_valid is a one-cycle strobe with no back-pressure.
// It is high in the cycle right after the edge that updated data_out. busy
// mirrors the FSM state (busy=1 means SETTLE), so the state is visible to checkers.
module sync_bus_stable_capture #(
  parameter int DW            = 16,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic          clk_b,
  input  logic          rst,
  input  logic [DW-1:0] data_sync,
  input  logic          en,
  input  logic          glitch_clr,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          busy,
  output logic [7:0]    glitch_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

  state_t           r_state;
  logic [DW-1:0]    r_samp;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_data_out;
  logic             r_data_valid;
  logic [7:0]       r_glitch_cnt;

  logic             w_reverted;
  logic             w_changed;
  logic             w_glitch;

  // Classify the current SETTLE sample. A reverted bus and a changed word are both rejected transients.
  always_comb begin
    w_reverted = (data_sync == r_data_out);
    w_changed  = (data_sync != r_samp);
    w_glitch   = 1'b0;
    if (r_state == ST_SETTLE && en && (w_reverted || w_changed)) begin
      w_glitch = 1'b1;
    end
  end

  // Capture FSM: track a candidate word and commit it once it has held long enough.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_samp       <= '0;
      r_cnt        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en && !w_reverted) begin
            r_state <= ST_SETTLE;
            r_samp  <= data_sync;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!en) begin
            r_state <= ST_IDLE;
          end else if (w_reverted) begin
            r_state <= ST_IDLE;
          end else if (w_changed) begin
            r_samp <= data_sync;
            r_cnt  <= CNT_W'(1);
          end else if (r_cnt == CNT_COMMIT) begin
            r_data_out   <= r_samp;
            r_data_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of rejected transients. A clear wins over a same-edge increment.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && r_glitch_cnt != 8'hFF) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = (r_state == ST_SETTLE);
  assign glitch_cnt = r_glitch_cnt;

endmodule
